// File: rtl/flag_unit_if.sv
// Bundles the ALU-side inputs and the flag/stack status outputs of flag_unit.
// Latency: none, this file only groups wires.
// Backpressure: none; the flag unit accepts a request every cycle.
interface flag_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic [1:0]       op_class;
  logic             upd;
  logic             push;
  logic             pop;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             of;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  // The driving side, for example the ALU or a testbench.
  modport master (
    output a, b, res, cout, op_class, upd, push, pop,
    input  zf, nf, cf, of, stk_full, stk_empty, stk_err
  );

  // The flag unit itself.
  modport slave (
    input  a, b, res, cout, op_class, upd, push, pop,
    output zf, nf, cf, of, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/flag_unit.sv
// Status-flag register (zf/nf/cf/of) with a save/restore LIFO for calls and interrupts.
// Latency: flags and stack status appear 1 cycle after the sampling edge.
// Backpressure: none; push-when-full and pop-when-empty set the sticky stk_err instead.
module flag_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  flag_unit_if.slave bus
);
  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  // Flag vectors are packed as {zf, nf, cf, of}.
  logic [3:0]       flags_q;
  logic [3:0]       flags_calc;
  logic [3:0]       flags_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_m1;
  logic             full_q;
  logic             empty_q;
  logic             err_q;
  logic             err_nxt;
  logic             wr_en;
  logic             do_push;
  logic             do_pop;
  logic             is_full;
  logic             is_empty;
  logic [3:0]       stk_mem [0:(2**IDX_W)-1];

  // Only the sign bits of the operands influence any flag.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.a[MSB-1:0], bus.b[MSB-1:0]};

  // A simultaneous push and pop cancel each other out.
  assign do_push  = bus.push & ~bus.pop;
  assign do_pop   = bus.pop & ~bus.push;
  assign is_full  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign is_empty = (cnt_q == '0);
  assign cnt_m1   = cnt_q - CNT_W'(1);

  // Combinational flag computation from the current ALU result.
  always_comb begin
    flags_calc[3] = (bus.res == '0);
    flags_calc[2] = bus.res[MSB];
    flags_calc[1] = 1'b0;
    flags_calc[0] = 1'b0;
    case (bus.op_class)
      OP_ADD: begin
        flags_calc[1] = bus.cout;
        flags_calc[0] = (bus.a[MSB] == bus.b[MSB]) & (bus.res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        // Subtraction is a + ~b + 1, so a missing carry means a borrow.
        flags_calc[1] = ~bus.cout;
        flags_calc[0] = (bus.a[MSB] != bus.b[MSB]) & (bus.res[MSB] != bus.a[MSB]);
      end
      OP_SHIFT: flags_calc[1] = bus.cout;
      OP_LOGIC: flags_calc[1] = 1'b0;
      default:  flags_calc[1] = 1'b0;
    endcase
  end

  // Next-state selection: pop beats upd, and push saves the pre-update flags.
  always_comb begin
    flags_nxt = flags_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    wr_en     = 1'b0;
    if (do_pop) begin
      if (is_empty) begin
        err_nxt = 1'b1;
      end else begin
        flags_nxt = stk_mem[cnt_m1[IDX_W-1:0]];
        cnt_nxt   = cnt_m1;
      end
    end else begin
      if (bus.upd) begin
        flags_nxt = flags_calc;
      end
      if (do_push) begin
        if (is_full) begin
          err_nxt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Flag register, stack pointer and registered status decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == CNT_W'(STACK_DEPTH));
      empty_q <= (cnt_nxt == '0);
      err_q   <= err_nxt;
    end
  end

  // Stack storage is left unreset; only the pointer defines valid entries.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      stk_mem[cnt_q[IDX_W-1:0]] <= flags_q;
    end
  end

  assign bus.zf        = flags_q[3];
  assign bus.nf        = flags_q[2];
  assign bus.cf        = flags_q[1];
  assign bus.of        = flags_q[0];
  assign bus.stk_full  = full_q;
  assign bus.stk_empty = empty_q;
  assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: directed vectors push hand-computed expectations,
// a monitor pops and compares the registered outputs one cycle later.
// Expected word layout: {zf, nf, cf, of, stk_full, stk_empty, stk_err}.
module tb_flag_unit;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] LOG = 2'b10;
  localparam logic [1:0] SHF = 2'b11;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [6:0] exp_q  [$];
  string      name_q [$];

  flag_unit_if #(.WIDTH(16)) bus ();

  flag_unit #(.WIDTH(16), .STACK_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the outputs expected after that edge.
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vr,
                      input logic vc, input logic [1:0] vop, input logic vu,
                      input logic vpu, input logic vpo, input logic vrst,
                      input logic [6:0] e, input string nm);
    @(negedge clk);
    bus.a        = va;
    bus.b        = vb;
    bus.res      = vr;
    bus.cout     = vc;
    bus.op_class = vop;
    bus.upd      = vu;
    bus.push     = vpu;
    bus.pop      = vpo;
    rst          = vrst;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    logic [6:0] got;
    logic [6:0] e;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {bus.zf, bus.nf, bus.cf, bus.of, bus.stk_full, bus.stk_empty, bus.stk_err};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL %s: got zf/nf/cf/of/full/empty/err=%b, want %b", nm, got, e);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.res      = '0;
    bus.cout     = 1'b0;
    bus.op_class = ADD;
    bus.upd      = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;

    //    a        b        res      c     op   upd  psh  pop  rst   expected       name
    step(16'h0000, 16'h0000, 16'h0000, 1'b0, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000_010, "reset");
    step(16'h7FFF, 16'h0001, 16'h8000, 1'b0, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0101_010, "add_ovf");
    step(16'hFFFF, 16'h0001, 16'h0000, 1'b1, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010_010, "add_carry");
    step(16'h0005, 16'h0007, 16'hFFFE, 1'b0, SUB, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0110_010, "sub_borrow");
    step(16'hFFFF, 16'h0001, 16'h0000, 1'b1, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1010_010, "load_1010");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1010_000, "push_1010");
    step(16'h7FFF, 16'h0001, 16'h8000, 1'b0, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0101_000, "load_0101");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0101_000, "push_0101");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0101_000, "pop_first");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1010_010, "pop_second");
    // Fill the stack while updating: each push saves the flags from before that edge.
    step(16'h7FFF, 16'h0001, 16'h8000, 1'b0, ADD, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0101_000, "push_upd1");
    step(16'h0005, 16'h0007, 16'hFFFE, 1'b0, SUB, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0110_000, "push_upd2");
    step(16'h00F0, 16'h0F00, 16'h0000, 1'b0, LOG, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1000_000, "push_upd_logic");
    step(16'h0000, 16'h0000, 16'h0000, 1'b0, LOG, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1000_100, "push_to_full");
    step(16'hFFFF, 16'h0001, 16'h0000, 1'b1, ADD, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1010_101, "push_over_full");
    // Stack now holds 1010, 0101, 0110, 1000 (bottom to top).
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1000_001, "pop_beats_upd");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0110_001, "pop_0110");
    step(16'h0000, 16'h0000, 16'h0001, 1'b1, SHF, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0010_001, "push_pop_upd");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0101_001, "pop_0101");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1010_011, "pop_to_empty");
    step(16'h7FFF, 16'h0001, 16'h8000, 1'b0, ADD, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1010_011, "pop_when_empty");
    step(16'h0000, 16'h0000, 16'h8000, 1'b0, SHF, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0100_011, "shift_nc");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0100_001, "push_one");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0000_010, "rst_mid_push");
    step(16'h0000, 16'h0000, 16'h1234, 1'b0, LOG, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000_011, "pop_after_rst");
    step(16'h8000, 16'h0001, 16'h7FFF, 1'b1, SUB, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001_011, "sub_ovf");
    step(16'h0003, 16'h0003, 16'h0000, 1'b1, SUB, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000_011, "sub_zero");

    @(negedge clk);
    bus.upd  = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Status-flag producer for the conditional-jump path.
- Computes zero/negative/carry/overflow from each ALU result and holds them in a flag register. These registered flags feed the jump-condition selector, which picks one flag to drive jmp.
- Contains a small LIFO so flags can be saved and restored around calls and interrupts.
- Sits between the ALU output and the branch-condition logic.

Parameters:
- WIDTH, 16, ALU operand/result width in bits (>= 2).
- STACK_DEPTH, 4, number of 4-bit flag entries in the save/restore LIFO (>= 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  ALU operand A.
- b  input  WIDTH  ALU operand B.
- res  input  WIDTH  ALU result for a/b.
- cout  input  1  ALU carry-out. For add: the carry. For sub (a + ~b + 1): the carry. For shift: the last bit shifted out.
- op_class  input  2  operation class: 00 add, 01 sub, 10 logic, 11 shift.
- upd  input  1  load the computed flags this cycle.
- push  input  1  save the current flag register onto the LIFO.
- pop  input  1  restore the flag register from the LIFO top.
- zf  output  1  registered zero flag.
- nf  output  1  registered negative flag.
- cf  output  1  registered carry/borrow flag.
- of  output  1  registered signed-overflow flag.
- stk_full  output  1  LIFO holds STACK_DEPTH entries.
- stk_empty  output  1  LIFO holds 0 entries.
- stk_err  output  1  sticky flag: push-when-full or pop-when-empty occurred.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. On rst=1 at a rising edge:
  - zf=nf=cf=of=0, LIFO count=0, stk_empty=1, stk_full=0, stk_err=0.
  - rst overrides all other inputs in that cycle, including mid-push or mid-pop.
- Flag computation is combinational from a, b, res, cout, op_class:
  - zf = (res == 0).
  - nf = res[WIDTH-1].
  - add: cf = cout; of = (a[MSB]==b[MSB]) & (res[MSB]!=a[MSB]).
  - sub (a-b): cf = ~cout (borrow); of = (a[MSB]!=b[MSB]) & (res[MSB]!=a[MSB]).
  - logic: cf = 0, of = 0.
  - shift: cf = cout, of = 0.
- Latency: computed flags become visible on the outputs 1 cycle after the edge sampling upd=1. When upd=0, the flags hold.
- push (and no pop): the current registered flags {zf,nf,cf,of} are written at the top; count+1.
  - If upd=1 in the same cycle, the pre-update flags are saved and the flag register still updates.
- pop (and no push): the flag register loads the top entry; count-1.
  - pop has priority over upd; upd is ignored in that cycle.
- push=1 and pop=1 together: LIFO and count unchanged, no error; upd is applied normally.
- Push when full: the entry is dropped, count unchanged, stk_err set to 1. upd is still applied.
- Pop when empty: the flag register is unchanged, count unchanged, stk_err set to 1. upd is ignored.
- stk_err clears only on rst.
- stk_full and stk_empty are registered and decoded from count; they reflect the post-edge count.
- Stack RAM contents are not reset; only count is.

Test Plan:
- Reset with WIDTH=16 → next cycle all flags 0, stk_empty=1, stk_full=0, stk_err=0.
- upd, add: a=0x7FFF, b=0x0001, res=0x8000, cout=0 → next cycle zf=0, nf=1, cf=0, of=1.
- upd, add: a=0xFFFF, b=0x0001, res=0x0000, cout=1 → zf=1, nf=0, cf=1, of=0. Then upd, sub: a=0x0005, b=0x0007, res=0xFFFE, cout=0 → zf=0, nf=1, cf=1, of=0.
- Load flags 1010 (zf,nf,cf,of), push; load 0101, push; then pop twice:
  - After the 1st pop: flags 0101. After the 2nd pop: flags 1010, stk_empty=1. stk_err stays 0.
- Push 5 times with STACK_DEPTH=4 → stk_full=1 after the 4th push, stk_err=1 after the 5th. Then pop 5 times → 5th pop leaves flags unchanged, stk_empty=1, stk_err still 1.
- Same-cycle checks:
  - push+upd (logic, res=0) with flags 0110 → stored entry 0110, flags become 1000.
  - pop+upd → popped value wins.
  - push+pop → count unchanged.
  - Assert rst during a push → count=0.
